// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command stream into APB setup/access
// transfers with completer select decode, wait-state timeout and a held response.
module apb_requester #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 1,
  parameter int TIMEOUT    = 256,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int SEL_W     = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_W-1:0]     cmd_strb,
  input  logic [2:0]            cmd_prot,
  input  logic [SEL_W-1:0]      cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [NUM_SEL-1:0]    psel,
  output logic                  penable,
  output logic [STRB_W-1:0]     pstrb,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // A zero TIMEOUT still needs a legal one-bit counter even though it is never consulted.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               sel_ok_s;
  logic [NUM_SEL-1:0] sel_dec_s;
  logic               timeout_hit_s;

  // Completer index decode and timeout detection.
  always_comb begin
    sel_ok_s  = (int'(cmd_sel) < NUM_SEL);
    sel_dec_s = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      sel_dec_s[i] = (int'(cmd_sel) == i);
    end
    if (TIMEOUT != 0) begin
      timeout_hit_s = (wait_cnt_r == CNT_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);

  // Transfer state machine; all APB and response outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      pstrb       <= '0;
      pwdata      <= '0;
      pprot       <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            if (sel_ok_s) begin
              state_r    <= ST_SETUP;
              rsp_slverr <= 1'b0;
              psel       <= sel_dec_s;
              paddr      <= cmd_addr;
              pwrite     <= cmd_write;
              pprot      <= cmd_prot;
              pwdata     <= cmd_write ? cmd_wdata : '0;
              pstrb      <= cmd_write ? cmd_strb : '0;
            end else begin
              // Decode error: answer straight away without touching the bus.
              state_r    <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_slverr <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state_r    <= ST_ACCESS;
          penable    <= 1'b1;
          wait_cnt_r <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            state_r     <= ST_RESP;
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
          end else if (timeout_hit_s) begin
            state_r     <= ST_RESP;
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          psel      <= '0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_requester.md
# apb_requester

Parametrised APB4 requester that converts a valid/ready command stream into APB setup/access transfers and returns a buffered response. It generalises the team's fixed APB signal bundle (11-bit address, 32-bit data, single select) to configurable address/data width and multiple completer selects. It adds a wait-state timeout and address-select decode errors. It sits between a register-access agent (CPU bridge or test sequencer) and one or more APB completers such as the GPIO controller.

## Interface
- ADDR_WIDTH, 11, width of cmd_addr/paddr
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32; strobe width STRB_W = DATA_WIDTH/8
- NUM_SEL, 1, number of completer selects (psel bits); SEL_W = max(1, $clog2(NUM_SEL))
- TIMEOUT, 256, max ACCESS cycles waiting for pready; 0 disables timeout

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high at clk edge
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_W  write byte strobes
- cmd_prot  in  3  protection attributes
- cmd_sel  in  SEL_W  completer index
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high at clk edge
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_slverr  out  1  completer error or decode error
- rsp_timeout  out  1  pready timeout
- paddr  out  ADDR_WIDTH; pwrite  out  1; psel  out  NUM_SEL (one-hot or zero); penable  out  1; pstrb  out  STRB_W; pwdata  out  DATA_WIDTH; pprot  out  3
- prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1

## Operation
- States: IDLE, SETUP, ACCESS, RESP. One outstanding transfer.
- IDLE: cmd_ready=1. On cmd_valid, capture command into registers.
  - If cmd_sel < NUM_SEL, go to SETUP.
  - If cmd_sel >= NUM_SEL, go to RESP with rsp_slverr=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
- SETUP (exactly 1 cycle): psel[cmd_sel]=1, penable=0, and paddr/pwrite/pprot driven from the captured command.
  - Writes: pwdata=wdata, pstrb=strb.
  - Reads: pwdata=0, pstrb=0 (APB4 rule).
  - Then go to ACCESS. Clear the wait counter.
- ACCESS: penable=1; all other APB outputs held stable.
  - pready=1 at edge: capture prdata (reads only; writes give 0) and pslverr. Go to RESP.
  - pready=0 at edge: increment the wait counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, abort: rsp_timeout=1, rsp_slverr=0, rsp_rdata=0, go to RESP.
- RESP: psel=0, penable=0, rsp_valid=1, response fields held stable. On rsp_ready, go to IDLE.
- paddr, pwrite, pwdata, pstrb and pprot retain their last values outside transfers, except that reads force pwdata/pstrb to 0.
- Wait counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- cmd_ready is low in SETUP, ACCESS and RESP. cmd_valid is ignored in those states.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; cmd_ready=1; rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel, penable, paddr, pwrite, pwdata, pstrb, pprot all 0. cmd_valid is ignored while rst_n is low.
- Reset asserted mid-transfer: psel/penable drop immediately and the transfer is abandoned; no response is produced.
- All outputs are registered except cmd_ready, which is decoded from the state.
- Latency, command accept edge N:
  - SETUP in cycle N+1.
  - ACCESS from N+2.
  - With pready high in the first ACCESS cycle, rsp_valid rises at N+3.
  - Zero-wait throughput: one transfer per 4 cycles when rsp_ready is held high.
- Each completer wait cycle adds one cycle.
- Timeout: ACCESS is exited at the edge on which the TIMEOUT-th consecutive pready=0 sample is taken. Exactly TIMEOUT ACCESS cycles elapse before abort.
- pready and timeout on the same edge: pready wins (normal completion).
- Decode error: rsp_valid is asserted the cycle after accept.

## Test plan
- Zero-wait write, sel 0, addr 0x004, wdata 0xDEADBEEF, strb 0b0101 -> one SETUP and one ACCESS with pstrb=0101; rsp_valid 3 cycles after accept; rsp_slverr=0, rsp_rdata=0.
- Read with 3 wait states, prdata=0x12345678 -> penable high for 4 cycles with pstrb=0 and pwdata=0; rsp_rdata=0x12345678.
- TIMEOUT=8, pready tied low -> abort after 8 ACCESS cycles; rsp_timeout=1, psel=0 next cycle; the next command proceeds normally.
- pslverr=1 with pready on a write -> rsp_slverr=1; a subsequent read returns clean.
- NUM_SEL=3, cmd_sel=3 -> no psel activity; rsp_slverr=1 one cycle after accept. cmd_sel=2 -> psel=0b100.
- rsp_ready held low for 5 cycles -> response stable and cmd_ready low. rst_n pulsed during ACCESS -> all outputs 0 immediately and no response emitted.
